tlb_plru_assoc: RTL and testbench

- Parametrised set-associative TLB with a generic tree-PLRU replacement policy. It is the next generation of the fixed 8-way TLB cache.
- Adds per-entry valid bits, a request/response handshake, a page-walker refill handshake with fault reporting, and global or per-PCID flush.
- Sits between the load/store address path and the page-table walker.

---
 rtl/tlb_plru_assoc.sv | 245 ++++++++++++++++++++++++
 tb/tb_tlb_plru_assoc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_plru_assoc.sv
// Set-associative TLB with tree-PLRU replacement, walker refill handshake and
// global / per-PCID flush. One lookup in flight at a time.
//
// state  | meaning
// IDLE   | accept a request, or start a pending/requested flush
// LOOKUP | compare all ways of the latched set
// WAIT   | walk_req held high until the walker answers
// FILL   | write the victim way (unless faulted) and respond
// FLUSH  | invalidate all entries or those of one PCID
module tlb_plru_assoc #(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int NSET  = 8,
    parameter int NWAY  = 8,
    parameter int SPCID = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SADDR-1:0] req_va,
    input  logic [SPCID-1:0] req_pcid,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_fault,
    output logic [SADDR-1:0] resp_ta,
    output logic             walk_req,
    output logic [SADDR-1:0] walk_va,
    output logic [SPCID-1:0] walk_pcid,
    input  logic             refill_valid,
    input  logic [SADDR-1:0] refill_pa,
    input  logic             refill_fault,
    input  logic             flush_all,
    input  logic             flush_pcid_en,
    input  logic [SPCID-1:0] flush_pcid
);
    localparam int SIDX = $clog2(NSET);
    localparam int SWAY = $clog2(NWAY);
    localparam int STAG = SADDR - SPAGE - SIDX;
    localparam int SPPN = SADDR - SPAGE;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_FILL, S_FLUSH} state_t;
    state_t state, state_nxt;

    logic [NWAY-1:0] ent_valid [NSET];
    logic [STAG-1:0] ent_tag   [NSET][NWAY];
    logic [SPCID-1:0] ent_pcid [NSET][NWAY];
    logic [SPPN-1:0] ent_ppn   [NSET][NWAY];
    logic [NWAY-2:0] plru_q    [NSET];

    logic [SADDR-1:0] va_q;
    logic [SPCID-1:0] pcid_q;
    logic [SPPN-1:0]  refill_ppn_q;
    logic             refill_fault_q;
    logic             pend_all, pend_pcid_en;
    logic [SPCID-1:0] pend_pcid;
    logic             pend_all_nxt, pend_pcid_en_nxt;
    logic [SPCID-1:0] pend_pcid_nxt;
    logic             flush_in, flush_pending;

    logic [SIDX-1:0] set_idx;
    logic [STAG-1:0] tag_in;
    logic            hit, have_free;
    logic [SWAY-1:0] hit_way, free_way, victim;
    logic            unused_refill_ofs;

    // Walker returns a full address; only the page number is stored.
    assign unused_refill_ofs = ^refill_pa[SPAGE-1:0];

    function automatic logic [NWAY-2:0] plru_touch(input logic [NWAY-2:0] bits,
                                                   input logic [SWAY-1:0] way);
        logic [NWAY-2:0] r;
        logic [SWAY-1:0] node;
        r    = bits;
        node = '0;
        for (int lvl = SWAY - 1; lvl >= 0; lvl--) begin
            r[node] = ~way[lvl];
            node    = (node << 1) + SWAY'(1) + SWAY'(way[lvl]);
        end
        return r;
    endfunction

    function automatic logic [SWAY-1:0] plru_victim(input logic [NWAY-2:0] bits);
        logic [SWAY-1:0] node, v;
        logic            b;
        node = '0;
        v    = '0;
        for (int lvl = SWAY - 1; lvl >= 0; lvl--) begin
            b      = bits[node];
            v[lvl] = b;
            node   = (node << 1) + SWAY'(1) + SWAY'(b);
        end
        return v;
    endfunction

    assign flush_in      = flush_all | flush_pcid_en;
    assign flush_pending = pend_all | pend_pcid_en;
    assign req_ready     = !rst && (state == S_IDLE) && !flush_in && !flush_pending;
    assign set_idx       = va_q[SPAGE+SIDX-1:SPAGE];
    assign tag_in        = va_q[SADDR-1:SPAGE+SIDX];

    // Descending scan so the lowest matching / lowest free way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        have_free = 1'b0;
        free_way  = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (ent_valid[set_idx][w] && ent_tag[set_idx][w] == tag_in &&
                ent_pcid[set_idx][w] == pcid_q) begin
                hit     = 1'b1;
                hit_way = SWAY'(w);
            end
            if (!ent_valid[set_idx][w]) begin
                have_free = 1'b1;
                free_way  = SWAY'(w);
            end
        end
        victim = have_free ? free_way : plru_victim(plru_q[set_idx]);
    end

    // Two different pending PCIDs cannot both be held, so they escalate to a full flush.
    always_comb begin
        pend_all_nxt     = pend_all;
        pend_pcid_en_nxt = pend_pcid_en;
        pend_pcid_nxt    = pend_pcid;
        if (state == S_FLUSH) begin
            pend_all_nxt     = 1'b0;
            pend_pcid_en_nxt = 1'b0;
        end
        pend_all_nxt  = pend_all_nxt | flush_all |
                        (pend_pcid_en_nxt && flush_pcid_en && pend_pcid_nxt != flush_pcid);
        pend_pcid_nxt = pend_pcid_en_nxt ? pend_pcid_nxt : flush_pcid;
        pend_pcid_en_nxt = pend_pcid_en_nxt | flush_pcid_en;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_in || flush_pending)    state_nxt = S_FLUSH;
                else if (req_valid && req_ready) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: state_nxt = hit ? S_IDLE : S_WAIT;
            S_WAIT:   if (refill_valid) state_nxt = S_FILL;
            S_FILL:   state_nxt = S_IDLE;
            S_FLUSH:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_fault     <= 1'b0;
            resp_ta        <= '0;
            walk_req       <= 1'b0;
            walk_va        <= '0;
            walk_pcid      <= '0;
            va_q           <= '0;
            pcid_q         <= '0;
            refill_ppn_q   <= '0;
            refill_fault_q <= 1'b0;
            pend_all       <= 1'b0;
            pend_pcid_en   <= 1'b0;
            pend_pcid      <= '0;
            for (int s = 0; s < NSET; s++) begin
                ent_valid[s] <= '0;
                plru_q[s]    <= '0;
            end
        end else begin
            resp_valid   <= 1'b0;
            pend_all     <= pend_all_nxt;
            pend_pcid_en <= pend_pcid_en_nxt;
            pend_pcid    <= pend_pcid_nxt;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        va_q   <= req_va;
                        pcid_q <= req_pcid;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        resp_valid      <= 1'b1;
                        resp_hit        <= 1'b1;
                        resp_fault      <= 1'b0;
                        resp_ta         <= {ent_ppn[set_idx][hit_way], va_q[SPAGE-1:0]};
                        plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
                    end else begin
                        walk_req  <= 1'b1;
                        walk_va   <= va_q;
                        walk_pcid <= pcid_q;
                    end
                end
                S_WAIT: begin
                    if (refill_valid) begin
                        walk_req       <= 1'b0;
                        refill_ppn_q   <= refill_pa[SADDR-1:SPAGE];
                        refill_fault_q <= refill_fault;
                    end
                end
                S_FILL: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_fault <= refill_fault_q;
                    if (refill_fault_q) begin
                        resp_ta <= '0;
                    end else begin
                        resp_ta                    <= {refill_ppn_q, va_q[SPAGE-1:0]};
                        ent_valid[set_idx][victim] <= 1'b1;
                        plru_q[set_idx]            <= plru_touch(plru_q[set_idx], victim);
                    end
                end
                S_FLUSH: begin
                    for (int s = 0; s < NSET; s++) begin
                        if (pend_all) begin
                            ent_valid[s] <= '0;
                            plru_q[s]    <= '0;
                        end else if (pend_pcid_en) begin
                            for (int w = 0; w < NWAY; w++) begin
                                if (ent_pcid[s][w] == pend_pcid) ent_valid[s][w] <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL && !refill_fault_q) begin
            ent_tag[set_idx][victim]  <= tag_in;
            ent_pcid[set_idx][victim] <= pcid_q;
            ent_ppn[set_idx][victim]  <= refill_ppn_q;
        end
    end
endmodule

// File: tb/tb_tlb_plru_assoc.sv
// Directed bench for tlb_plru_assoc: a page-level TLB model with range-based
// tree-PLRU predicts every response, checked by one compare process.
module tb_tlb_plru_assoc;
    localparam int NSET = 8;
    localparam int NWAY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_va;
    logic [11:0] req_pcid;
    logic        resp_valid, resp_hit, resp_fault;
    logic [63:0] resp_ta;
    logic        walk_req;
    logic [63:0] walk_va;
    logic [11:0] walk_pcid;
    logic        refill_valid;
    logic [63:0] refill_pa;
    logic        refill_fault;
    logic        flush_all, flush_pcid_en;
    logic [11:0] flush_pcid;

    always #5 clk = ~clk;

    tlb_plru_assoc dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fault(resp_fault), .resp_ta(resp_ta),
        .walk_req(walk_req), .walk_va(walk_va), .walk_pcid(walk_pcid),
        .refill_valid(refill_valid), .refill_pa(refill_pa), .refill_fault(refill_fault),
        .flush_all(flush_all), .flush_pcid_en(flush_pcid_en), .flush_pcid(flush_pcid)
    );

    int checks = 0;
    int errors = 0;
    int resp_count = 0;

    typedef struct {
        bit          hit;
        bit          fault;
        logic [63:0] ta;
    } exp_t;
    exp_t exp_q[$];

    bit          m_valid [NSET][NWAY];
    logic [51:0] m_vpn   [NSET][NWAY];
    logic [11:0] m_pcid  [NSET][NWAY];
    logic [51:0] m_ppn   [NSET][NWAY];
    bit          m_tree  [NSET][NWAY-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic int set_of(input logic [63:0] va);
        return int'(va[14:12]);
    endfunction

    function automatic int m_find(input logic [63:0] va, input logic [11:0] pc);
        int s;
        s = set_of(va);
        for (int w = 0; w < NWAY; w++)
            if (m_valid[s][w] && m_vpn[s][w] == va[63:12] && m_pcid[s][w] == pc) return w;
        return -1;
    endfunction

    // Each tree node covers a range of ways; its bit names the half holding the victim.
    function automatic void m_touch(input int s, input int w);
        int lo, size, node, half;
        lo = 0; size = NWAY; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (w < lo + half) begin
                m_tree[s][node] = 1'b1;
                node = 2 * node + 1;
            end else begin
                m_tree[s][node] = 1'b0;
                lo   = lo + half;
                node = 2 * node + 2;
            end
            size = half;
        end
    endfunction

    function automatic int m_victim(input int s);
        int lo, size, node, half;
        for (int w = 0; w < NWAY; w++) if (!m_valid[s][w]) return w;
        lo = 0; size = NWAY; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (m_tree[s][node]) begin
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
            size = half;
        end
        return lo;
    endfunction

    function automatic void m_clear_all();
        for (int s = 0; s < NSET; s++) begin
            for (int w = 0; w < NWAY; w++) m_valid[s][w] = 1'b0;
            for (int n = 0; n < NWAY - 1; n++) m_tree[s][n] = 1'b0;
        end
    endfunction

    function automatic void m_flush_pcid(input logic [11:0] pc);
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NWAY; w++)
                if (m_pcid[s][w] == pc) m_valid[s][w] = 1'b0;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (!rst && resp_valid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                timeout_fail("unexpected_resp");
            end else begin
                e = exp_q.pop_front();
                chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                chk("resp_fault", 64'(resp_fault), 64'(e.fault));
                chk("resp_ta", resp_ta, e.ta);
            end
        end
    end

    task automatic wait_resp(input int prev, output int n);
        n = 0;
        while (resp_count == prev && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (resp_count == prev) timeout_fail("resp_wait");
    endtask

    task automatic do_req(input logic [63:0] va, input logic [11:0] pc, input logic [63:0] pa,
                          input bit flt, input bit flush_wait, input bit rst_wait,
                          output int way);
        int  s, n, prev;
        bit  ok;
        exp_t e;
        s   = set_of(va);
        way = m_find(va, pc);
        ok  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin timeout_fail("req_ready_wait"); return; end
        if (way >= 0) begin
            m_touch(s, way);
            e.hit = 1'b1; e.fault = 1'b0; e.ta = {m_ppn[s][way], va[11:0]};
            exp_q.push_back(e);
        end
        prev      = resp_count;
        req_valid = 1'b1; req_va = va; req_pcid = pc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (way >= 0) begin
            wait_resp(prev, n);
            chk("hit_latency", 64'(n), 64'd2);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (walk_req) begin ok = 1'b1; break; end
        end
        if (!ok) begin timeout_fail("walk_req_wait"); return; end
        chk("walk_va", walk_va, va);
        chk("walk_pcid", 64'(walk_pcid), 64'(pc));
        if (flush_wait) begin
            flush_all = 1'b1;
            @(negedge clk);
            flush_all = 1'b0;
            chk("walk_req_held", 64'(walk_req), 64'd1);
        end
        if (rst_wait) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_walk_req", 64'(walk_req), 64'd0);
            chk("rst_req_ready_mid", 64'(req_ready), 64'd0);
            rst = 1'b0;
            m_clear_all();
            exp_q.delete();
            prev = resp_count;
            refill_valid = 1'b1; refill_pa = pa; refill_fault = flt;
            @(negedge clk);
            refill_valid = 1'b0;
            repeat (6) @(negedge clk);
            #1;
            chk("late_refill_ignored", 64'(resp_count), 64'(prev));
            way = -1;
            return;
        end
        if (flt) begin
            e.hit = 1'b0; e.fault = 1'b1; e.ta = '0;
        end else begin
            way = m_victim(s);
            m_valid[s][way] = 1'b1;
            m_vpn[s][way]   = va[63:12];
            m_pcid[s][way]  = pc;
            m_ppn[s][way]   = pa[63:12];
            m_touch(s, way);
            e.hit = 1'b0; e.fault = 1'b0; e.ta = {pa[63:12], va[11:0]};
        end
        exp_q.push_back(e);
        if (flush_wait) m_clear_all();
        refill_valid = 1'b1; refill_pa = pa; refill_fault = flt;
        @(negedge clk);
        refill_valid = 1'b0; refill_fault = 1'b0;
        wait_resp(prev, n);
    endtask

    task automatic do_flush(input bit all, input bit en, input logic [11:0] pc, input bit with_req);
        @(negedge clk);
        flush_all = all; flush_pcid_en = en; flush_pcid = pc;
        if (with_req) begin
            req_valid = 1'b1; req_va = 64'h5000; req_pcid = 12'd1;
            #1;
            chk("ready_with_flush", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        flush_all = 1'b0; flush_pcid_en = 1'b0; req_valid = 1'b0;
        if (all) m_clear_all();
        else if (en) m_flush_pcid(pc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [63:0] va_a, va_b, va_c, va_d, va_e, va_t;
        int w;
        rst = 1'b1; req_valid = 1'b0; req_va = '0; req_pcid = '0;
        refill_valid = 1'b0; refill_pa = '0; refill_fault = 1'b0;
        flush_all = 1'b0; flush_pcid_en = 1'b0; flush_pcid = '0;
        m_clear_all();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_resp_ta", resp_ta, 64'd0);
        chk("rst_walk_req", 64'(walk_req), 64'd0);
        chk("rst_walk_va", walk_va, 64'd0);
        chk("rst_walk_pcid", 64'(walk_pcid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        va_a = 64'h0000_1234_5000_0ABC;
        va_b = 64'h0000_0000_0000_1000;
        do_req(va_a, 12'd3, 64'h9000_0000, 0, 0, 0, w);
        chk("first_fill_ta", resp_ta, 64'h9000_0ABC);
        chk("first_fill_hit", 64'(resp_hit), 64'd0);
        do_req(va_a, 12'd3, 64'h0, 0, 0, 0, w);
        chk("repeat_hit", 64'(resp_hit), 64'd1);
        chk("repeat_hit_ta", resp_ta, 64'h9000_0ABC);
        do_req(va_a, 12'd4, 64'hA000_0000, 0, 0, 0, w);
        chk("pcid4_miss_ta", resp_ta, 64'hA000_0ABC);
        do_req(va_a, 12'd3, 64'h0, 0, 0, 0, w);
        chk("pcid3_still_hit", 64'(resp_hit), 64'd1);

        do_req(va_b, 12'd5, 64'hB000_0000, 0, 0, 0, w);
        do_flush(0, 1, 12'd3, 0);
        do_req(va_a, 12'd3, 64'h9100_0000, 0, 0, 0, w);
        chk("pcid3_flushed", 64'(resp_hit), 64'd0);
        do_req(va_b, 12'd5, 64'h0, 0, 0, 0, w);
        chk("pcid5_kept", 64'(resp_hit), 64'd1);
        do_req(va_a, 12'd4, 64'h0, 0, 0, 0, w);

        do_flush(1, 0, 12'd0, 1);
        do_req(va_b, 12'd5, 64'hB100_0000, 0, 0, 0, w);
        chk("flush_all_miss", 64'(resp_hit), 64'd0);
        do_req(va_a, 12'd4, 64'hA100_0000, 0, 0, 0, w);

        do_flush(1, 0, 12'd0, 0);
        for (int t = 0; t < 8; t++) begin
            va_t = (64'(t + 1) << 15) | 64'h123;
            do_req(va_t, 12'd7, 64'h00AB_0000_0000 + (64'(t) << 20), 0, 0, 0, w);
            chk("fill_order_way", 64'(w), 64'(t));
        end
        va_t = (64'd3 << 15) | 64'h123;
        do_req(va_t, 12'd7, 64'h0, 0, 0, 0, w);
        chk("touch_way2", 64'(w), 64'd2);
        va_t = (64'd9 << 15) | 64'h123;
        do_req(va_t, 12'd7, 64'h00CD_0000_0000, 0, 0, 0, w);
        chk("plru_victim_way", 64'(w), 64'd4);
        va_t = (64'd3 << 15) | 64'h123;
        do_req(va_t, 12'd7, 64'h0, 0, 0, 0, w);
        chk("way2_survives", 64'(resp_hit), 64'd1);
        va_t = (64'd5 << 15) | 64'h123;
        do_req(va_t, 12'd7, 64'h00EF_0000_0000, 0, 0, 0, w);
        chk("evicted_misses", 64'(resp_hit), 64'd0);

        va_c = 64'h0000_0000_0000_3000;
        do_req(va_c, 12'd1, 64'h0, 1, 0, 0, w);
        chk("fault_flag", 64'(resp_fault), 64'd1);
        chk("fault_ta", resp_ta, 64'd0);
        do_req(va_c, 12'd1, 64'hC000_0000, 0, 0, 0, w);
        chk("after_fault_miss", 64'(resp_hit), 64'd0);
        chk("after_fault_clear", 64'(resp_fault), 64'd0);

        va_d = 64'h0000_0000_0000_5000;
        do_req(va_d, 12'd2, 64'hD000_0000, 0, 1, 0, w);
        chk("flush_wait_ta", resp_ta, 64'hD000_0000);
        do_req(va_d, 12'd2, 64'hD100_0000, 0, 0, 0, w);
        chk("flush_wait_then_miss", 64'(resp_hit), 64'd0);

        va_e = 64'h0000_0000_0000_7000;
        do_req(va_e, 12'd2, 64'hE000_0000, 0, 0, 1, w);
        do_req(va_e, 12'd2, 64'hE100_0000, 0, 0, 0, w);
        chk("after_rst_miss", 64'(resp_hit), 64'd0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
